// File: rtl/s_axis_frame_parser.sv
// Strips the TUSER-marked header beat from a framed AXI-Stream, latches its timestamp,
// forwards payload through a single output register and reports frame length and errors.
module s_axis_frame_parser #(
    parameter int TIME_STAMP_WIDTH = 16,
    parameter int TDATA_WIDTH      = 64,
    parameter int MAX_BEATS        = 100,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                        AXIS_ACLK,
    input  logic                        AXIS_ARESET,
    input  logic [TDATA_WIDTH-1:0]      S_AXIS_TDATA,
    input  logic                        S_AXIS_TVALID,
    input  logic                        S_AXIS_TUSER,
    input  logic                        S_AXIS_TLAST,
    output logic                        S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0]      M_AXIS_TDATA,
    output logic                        M_AXIS_TVALID,
    output logic                        M_AXIS_TUSER,
    output logic                        M_AXIS_TLAST,
    input  logic                        M_AXIS_TREADY,
    output logic [TIME_STAMP_WIDTH-1:0] TIME_STAMP,
    output logic                        TS_VALID,
    output logic [CNT_WIDTH-1:0]        FRAME_LEN,
    output logic                        FRAME_DONE,
    output logic                        ERR_NOHDR,
    output logic                        ERR_TRUNC,
    output logic                        ERR_OVERLEN,
    output logic                        ERR_EMPTY,
    output logic [CNT_WIDTH-1:0]        FRAME_CNT,
    output logic [CNT_WIDTH-1:0]        ERR_CNT
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   beat_cnt;
    logic [CNT_WIDTH-1:0]   beat_nxt_p0;
    logic                   at_max_p0;
    logic                   in_hs_p0;
    logic                   out_hs;
    logic                   load_p0;
    logic                   err_evt_p0;
    logic [TDATA_WIDTH-1:0] data_p1;
    logic                   vld_p1;
    logic                   user_p1;
    logic                   last_p1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage p0: input handshake and per-beat decode
    assign S_AXIS_TREADY = !AXIS_ARESET && ((state != PAYLOAD) || !vld_p1 || M_AXIS_TREADY);
    assign in_hs_p0      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign out_hs        = vld_p1 && M_AXIS_TREADY;
    assign beat_nxt_p0   = beat_cnt + 1'b1;
    assign at_max_p0     = (beat_nxt_p0 == CNT_WIDTH'(MAX_BEATS));
    assign load_p0       = in_hs_p0 && (state == PAYLOAD) && !S_AXIS_TUSER;

    always_comb begin
        err_evt_p0 = 1'b0;
        if (in_hs_p0) begin
            case (state)
                IDLE:    err_evt_p0 = !S_AXIS_TUSER || S_AXIS_TLAST;
                PAYLOAD: err_evt_p0 = S_AXIS_TUSER || (!S_AXIS_TLAST && at_max_p0);
                default: err_evt_p0 = 1'b0;
            endcase
        end
    end

    // Stage p1: output register and frame bookkeeping
    always_ff @(posedge AXIS_ACLK) begin
        if (load_p0) data_p1 <= S_AXIS_TDATA;
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            vld_p1      <= 1'b0;
            user_p1     <= 1'b0;
            last_p1     <= 1'b0;
            TIME_STAMP  <= '0;
            TS_VALID    <= 1'b0;
            FRAME_LEN   <= '0;
            FRAME_DONE  <= 1'b0;
            ERR_NOHDR   <= 1'b0;
            ERR_TRUNC   <= 1'b0;
            ERR_OVERLEN <= 1'b0;
            ERR_EMPTY   <= 1'b0;
            FRAME_CNT   <= '0;
            ERR_CNT     <= '0;
        end else begin
            TS_VALID    <= 1'b0;
            FRAME_DONE  <= 1'b0;
            ERR_NOHDR   <= 1'b0;
            ERR_TRUNC   <= 1'b0;
            ERR_OVERLEN <= 1'b0;
            ERR_EMPTY   <= 1'b0;
            if (out_hs) vld_p1 <= 1'b0;
            if (err_evt_p0) ERR_CNT <= sat_inc(ERR_CNT);
            if (in_hs_p0) begin
                case (state)
                    IDLE, PAYLOAD: begin
                        if (S_AXIS_TUSER) begin
                            // A header mid-payload abandons the old frame without a synthetic TLAST
                            TIME_STAMP <= S_AXIS_TDATA[TIME_STAMP_WIDTH-1:0];
                            TS_VALID   <= 1'b1;
                            beat_cnt   <= '0;
                            ERR_TRUNC  <= (state == PAYLOAD);
                            if (S_AXIS_TLAST) begin
                                ERR_EMPTY <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                state     <= PAYLOAD;
                            end
                        end else if (state == IDLE) begin
                            ERR_NOHDR <= 1'b1;
                            if (!S_AXIS_TLAST) state <= DROP;
                        end else begin
                            vld_p1   <= 1'b1;
                            user_p1  <= (beat_cnt == '0);
                            beat_cnt <= beat_nxt_p0;
                            if (S_AXIS_TLAST) begin
                                last_p1    <= 1'b1;
                                FRAME_LEN  <= beat_nxt_p0;
                                FRAME_DONE <= 1'b1;
                                FRAME_CNT  <= sat_inc(FRAME_CNT);
                                state      <= IDLE;
                            end else if (at_max_p0) begin
                                last_p1     <= 1'b1;
                                FRAME_LEN   <= beat_nxt_p0;
                                ERR_OVERLEN <= 1'b1;
                                state       <= DROP;
                            end else begin
                                last_p1 <= 1'b0;
                            end
                        end
                    end
                    DROP: begin
                        if (S_AXIS_TLAST) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign M_AXIS_TDATA  = data_p1;
    assign M_AXIS_TVALID = vld_p1;
    assign M_AXIS_TUSER  = user_p1;
    assign M_AXIS_TLAST  = last_p1;

endmodule

// File: tb/tb_s_axis_frame_parser.sv
// Bench for s_axis_frame_parser: table of input beats grouped into frames, a scoreboard of
// expected output beats, per-group strobe/counter checks, plus stall and reset sequences.
module tb_s_axis_frame_parser;

    localparam int TSW = 16;
    localparam int DW  = 64;
    localparam int MB  = 4;
    localparam int CW  = 3;

    logic          clk = 1'b0;
    logic          AXIS_ARESET;
    logic [DW-1:0] S_AXIS_TDATA;
    logic          S_AXIS_TVALID, S_AXIS_TUSER, S_AXIS_TLAST, S_AXIS_TREADY;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TVALID, M_AXIS_TUSER, M_AXIS_TLAST;
    logic          M_AXIS_TREADY;
    logic [TSW-1:0] TIME_STAMP;
    logic          TS_VALID, FRAME_DONE, ERR_NOHDR, ERR_TRUNC, ERR_OVERLEN, ERR_EMPTY;
    logic [CW-1:0] FRAME_LEN, FRAME_CNT, ERR_CNT;

    s_axis_frame_parser #(
        .TIME_STAMP_WIDTH(TSW), .TDATA_WIDTH(DW), .MAX_BEATS(MB), .CNT_WIDTH(CW)
    ) dut (
        .AXIS_ACLK(clk), .AXIS_ARESET(AXIS_ARESET),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TUSER(S_AXIS_TUSER), .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TUSER(M_AXIS_TUSER), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .TIME_STAMP(TIME_STAMP), .TS_VALID(TS_VALID),
        .FRAME_LEN(FRAME_LEN), .FRAME_DONE(FRAME_DONE),
        .ERR_NOHDR(ERR_NOHDR), .ERR_TRUNC(ERR_TRUNC),
        .ERR_OVERLEN(ERR_OVERLEN), .ERR_EMPTY(ERR_EMPTY),
        .FRAME_CNT(FRAME_CNT), .ERR_CNT(ERR_CNT)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic u, l, fwd, eu, el;
    } beat_t;

    typedef struct {
        int first, n, rmode;
        int ts_n, done_n, nohdr_n, trunc_n, over_n, empty_n;
        int len, fcnt, ecnt, tsv;
    } grp_t;

    typedef struct {
        logic [DW-1:0] d;
        logic u, l;
    } out_t;

    beat_t beats[$];
    grp_t  grps[$];
    out_t  sb[$];
    out_t  exp_o;

    int total = 0;
    int bad   = 0;
    int rmode = 0;
    int n_ts, n_done, n_nohdr, n_trunc, n_over, n_empty;
    logic stall_prev = 1'b0;
    logic [DW+1:0] held;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [DW-1:0] d, input logic u, l, fwd, eu, el);
        beats.push_back('{d, u, l, fwd, eu, el});
    endtask

    task automatic addg(input int first, rm, ts, dn, nh, tr, ov, em, len, fc, ec, tsv);
        grps.push_back('{first, beats.size() - first, rm, ts, dn, nh, tr, ov, em, len, fc, ec, tsv});
    endtask

    // M_AXIS_TREADY: 0 = always ready, 1 = toggling, 2 = held low
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       M_AXIS_TREADY = 1'b1;
            1:       M_AXIS_TREADY = !M_AXIS_TREADY;
            default: M_AXIS_TREADY = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        n_ts    += int'(TS_VALID);
        n_done  += int'(FRAME_DONE);
        n_nohdr += int'(ERR_NOHDR);
        n_trunc += int'(ERR_TRUNC);
        n_over  += int'(ERR_OVERLEN);
        n_empty += int'(ERR_EMPTY);
        if (AXIS_ARESET) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                if (!M_AXIS_TVALID || {M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST} !== held) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%0b %0h expected v=1 %0h",
                             M_AXIS_TVALID, {M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST}, held);
                end
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: got data=%0h user=%0b last=%0b expected none",
                             M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST);
                end else begin
                    exp_o = sb.pop_front();
                    if (M_AXIS_TDATA !== exp_o.d || M_AXIS_TUSER !== exp_o.u || M_AXIS_TLAST !== exp_o.l) begin
                        bad++;
                        $display("FAIL out_beat: got data=%0h user=%0b last=%0b expected data=%0h user=%0b last=%0b",
                                 M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST, exp_o.d, exp_o.u, exp_o.l);
                    end
                end
            end
            stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
            held = {M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TLAST};
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic u, l);
        int guard = 0;
        @(negedge clk);
        S_AXIS_TDATA = d; S_AXIS_TUSER = u; S_AXIS_TLAST = l; S_AXIS_TVALID = 1'b1;
        forever begin
            #1;
            if (S_AXIS_TREADY) begin
                @(posedge clk);
                #1 S_AXIS_TVALID = 1'b0;
                return;
            end
            guard++;
            if (guard > 200) begin
                chk("send_timeout", 64'd1, 64'd0);
                S_AXIS_TVALID = 1'b0;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int guard = 0;
        forever begin
            @(negedge clk); #1;
            if (sb.size() == 0 && !M_AXIS_TVALID) break;
            guard++;
            if (guard > 100) begin
                chk("drain_timeout", 64'(sb.size()), 64'd0);
                sb.delete();
                break;
            end
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        @(posedge clk); #1;
        n_ts = 0; n_done = 0; n_nohdr = 0; n_trunc = 0; n_over = 0; n_empty = 0;
    endtask

    task automatic run_groups(input int g0, g1);
        for (int g = g0; g < g1; g++) begin
            rmode = grps[g].rmode;
            clr_cnt();
            for (int i = grps[g].first; i < grps[g].first + grps[g].n; i++) begin
                if (beats[i].fwd) sb.push_back('{beats[i].d, beats[i].eu, beats[i].el});
                send(beats[i].d, beats[i].u, beats[i].l);
            end
            drain();
            rmode = 0;
            chk($sformatf("g%0d_ts_valid", g),  64'(n_ts),    64'(grps[g].ts_n));
            chk($sformatf("g%0d_frame_done", g), 64'(n_done), 64'(grps[g].done_n));
            chk($sformatf("g%0d_err_nohdr", g), 64'(n_nohdr), 64'(grps[g].nohdr_n));
            chk($sformatf("g%0d_err_trunc", g), 64'(n_trunc), 64'(grps[g].trunc_n));
            chk($sformatf("g%0d_err_overlen", g), 64'(n_over), 64'(grps[g].over_n));
            chk($sformatf("g%0d_err_empty", g), 64'(n_empty), 64'(grps[g].empty_n));
            chk($sformatf("g%0d_frame_len", g), 64'(FRAME_LEN), 64'(grps[g].len));
            chk($sformatf("g%0d_frame_cnt", g), 64'(FRAME_CNT), 64'(grps[g].fcnt));
            chk($sformatf("g%0d_err_cnt", g),   64'(ERR_CNT),   64'(grps[g].ecnt));
            chk($sformatf("g%0d_time_stamp", g), 64'(TIME_STAMP), 64'(grps[g].tsv));
        end
    endtask

    initial begin
        int f;
        // g0: basic 3-beat frame, upper header bits must not reach TIME_STAMP
        f = beats.size();
        add(64'hDEAD_0000_0000_1234, 1, 0, 0, 0, 0);
        add(64'hA1, 0, 0, 1, 1, 0); add(64'hA2, 0, 0, 1, 0, 0); add(64'hA3, 0, 1, 1, 0, 1);
        addg(f, 0, 1, 1, 0, 0, 0, 0, 3, 1, 0, 'h1234);
        // g1: same shape with output backpressure toggling
        f = beats.size();
        add(64'h2345, 1, 0, 0, 0, 0);
        add(64'hB1, 0, 0, 1, 1, 0); add(64'hB2, 0, 0, 1, 0, 0); add(64'hB3, 0, 1, 1, 0, 1);
        addg(f, 1, 1, 1, 0, 0, 0, 0, 3, 2, 0, 'h2345);
        // g2: overlength, 6 beats against a limit of 4
        f = beats.size();
        add(64'h0555, 1, 0, 0, 0, 0);
        add(64'hC1, 0, 0, 1, 1, 0); add(64'hC2, 0, 0, 1, 0, 0);
        add(64'hC3, 0, 0, 1, 0, 0); add(64'hC4, 0, 0, 1, 0, 1);
        add(64'hC5, 0, 0, 0, 0, 0); add(64'hC6, 0, 1, 0, 0, 0);
        addg(f, 0, 1, 0, 0, 0, 1, 0, 4, 2, 1, 'h0555);
        // g3: truncated frame followed by a new header
        f = beats.size();
        add(64'h0777, 1, 0, 0, 0, 0);
        add(64'hD1, 0, 0, 1, 1, 0); add(64'hD2, 0, 0, 1, 0, 0);
        add(64'h0042, 1, 0, 0, 0, 0); add(64'hD3, 0, 1, 1, 1, 1);
        addg(f, 0, 2, 1, 0, 1, 0, 0, 1, 3, 2, 'h0042);
        // g4 (after reset): headerless beats dropped, then a good frame
        f = beats.size();
        add(64'hE1, 0, 0, 0, 0, 0); add(64'hE2, 0, 1, 0, 0, 0);
        add(64'h0099, 1, 0, 0, 0, 0);
        add(64'hE3, 0, 0, 1, 1, 0); add(64'hE4, 0, 1, 1, 0, 1);
        addg(f, 0, 1, 1, 1, 0, 0, 0, 2, 1, 1, 'h0099);
        // g5: error counter saturates at 7
        f = beats.size();
        for (int i = 0; i < 8; i++) add(64'h5000 + 64'(i), 0, 1, 0, 0, 0);
        addg(f, 0, 0, 0, 8, 0, 0, 0, 2, 1, 7, 'h0099);
        // g6: frame counter saturates at 7
        f = beats.size();
        for (int i = 0; i < 7; i++) begin
            add(64'h0100 + 64'(i), 1, 0, 0, 0, 0);
            add(64'h6000 + 64'(i), 0, 1, 1, 1, 1);
        end
        addg(f, 0, 7, 7, 0, 0, 0, 0, 1, 7, 7, 'h0106);

        AXIS_ARESET = 1'b1; S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0;
        S_AXIS_TUSER = 1'b0; S_AXIS_TLAST = 1'b0; M_AXIS_TREADY = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_tready", 64'(S_AXIS_TREADY), 64'd0);
        chk("rst_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        chk("rst_frame_cnt", 64'(FRAME_CNT), 64'd0);
        chk("rst_err_cnt", 64'(ERR_CNT), 64'd0);
        chk("rst_strobes", 64'({TS_VALID, FRAME_DONE, ERR_NOHDR, ERR_TRUNC, ERR_OVERLEN, ERR_EMPTY}), 64'd0);
        AXIS_ARESET = 1'b0;
        @(negedge clk); #1;
        chk("idle_s_tready", 64'(S_AXIS_TREADY), 64'd1);

        run_groups(0, 4);

        // Output held by backpressure: input must stall while the register is full
        rmode = 2;
        sb.push_back('{64'h51, 1'b1, 1'b0});
        sb.push_back('{64'h52, 1'b0, 1'b1});
        send(64'h0111, 1, 0);
        send(64'h51, 0, 0);
        fork
            send(64'h52, 0, 1);
            begin
                repeat (2) @(negedge clk);
                #2;
                chk("stall_s_tready", 64'(S_AXIS_TREADY), 64'd0);
                chk("stall_m_tvalid", 64'(M_AXIS_TVALID), 64'd1);
                rmode = 0;
            end
        join
        drain();
        chk("stall_frame_cnt", 64'(FRAME_CNT), 64'd4);
        chk("stall_frame_len", 64'(FRAME_LEN), 64'd2);

        // Empty frame, then a reset while a payload beat sits in the output register
        clr_cnt();
        send(64'h0ABC, 1, 1);
        drain();
        chk("empty_err_empty", 64'(n_empty), 64'd1);
        chk("empty_ts_valid", 64'(n_ts), 64'd1);
        chk("empty_frame_done", 64'(n_done), 64'd0);
        chk("empty_err_cnt", 64'(ERR_CNT), 64'd3);
        chk("empty_time_stamp", 64'(TIME_STAMP), 64'h0ABC);
        rmode = 2;
        send(64'h0BCD, 1, 0);
        send(64'hF1, 0, 0);
        @(negedge clk); #1;
        chk("prerst_m_tvalid", 64'(M_AXIS_TVALID), 64'd1);
        AXIS_ARESET = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("midrst_s_tready", 64'(S_AXIS_TREADY), 64'd0);
        chk("midrst_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        chk("midrst_m_tlast", 64'(M_AXIS_TLAST), 64'd0);
        chk("midrst_frame_cnt", 64'(FRAME_CNT), 64'd0);
        chk("midrst_err_cnt", 64'(ERR_CNT), 64'd0);
        chk("midrst_frame_len", 64'(FRAME_LEN), 64'd0);
        chk("midrst_time_stamp", 64'(TIME_STAMP), 64'd0);
        rmode = 0;
        AXIS_ARESET = 1'b0;
        @(negedge clk);

        run_groups(4, 7);
        chk("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
